mem_access_ctrl: RTL and testbench

- Initiator side of the 8-word data memory port. Accepts load/store/add requests from the execute stage over a valid/ready handshake.
- Drives the memory strobes (wr_en, rd_en), word address, write data and adder operands. Captures the memory's rd_data and returns it over a valid/ready response channel.
- Single-outstanding: one request in flight at a time. Sits between the execute stage and the memory access block.

---
 rtl/mem_access_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the 8-word data memory port.
// Accepts one load/store/add request at a time over a valid/ready handshake,
// drives the memory strobes, address, write data and adder operands, captures
// mem_rd_data and returns it over a valid/ready response channel.
//
// Optional build macro: MEM_ACC_BOUNDS_CHK_EN rejects misaligned or
// out-of-range load/store addresses with resp_err (no memory access made).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready = state is IDLE)
//   req_op                   00 load, 01 store, 10 add, 11 reserved
//   req_addr                 byte address, word index = req_addr[MEM_ADDR_W+1:2]
//   req_wdata, req_a, req_b  store data, add operands
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_err      load data / sum (0 for store and errors), reject flag
//   mem_wr_en, mem_rd_en     memory strobes
//   mem_add, mem_data        memory word address and write data
//   mem_op1, mem_op2         memory adder operands
//   mem_rd_data              memory read / sum result
module mem_access_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_WORDS  = 8,
    parameter int unsigned MEM_ADDR_W = 3,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W-1:0]     req_a,
    input  logic [DATA_W-1:0]     req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W-1:0]     mem_op1,
    output logic [DATA_W-1:0]     mem_op2,
    input  logic [DATA_W-1:0]     mem_rd_data
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, state_n;
    logic [1:0]              op, op_n;
    logic                    err, err_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    resp_valid_n, resp_err_n, mem_wr_en_n, mem_rd_en_n;
    logic [DATA_W-1:0]       resp_data_n, mem_data_n, mem_op1_n, mem_op2_n;
    logic [MEM_ADDR_W-1:0]   mem_add_n;
    logic                    addr_bad;
    logic                    reject;
    logic [MEM_ADDR_W-1:0]   word_idx;

    assign req_ready = (state == IDLE);
    assign word_idx  = req_addr[MEM_ADDR_W+1:2];

    // Address rejection only exists in the bounds-checking build; add is never checked.
`ifdef MEM_ACC_BOUNDS_CHK_EN
    assign addr_bad = ((req_op == OP_LOAD) || (req_op == OP_STORE)) &&
                      ((req_addr[1:0] != 2'b00) || (req_addr >= 32'(MEM_WORDS * 4)));
`else
    logic unused_addr;
    assign addr_bad    = 1'b0;
    assign unused_addr = ^{req_addr[31:MEM_ADDR_W+2], req_addr[1:0], 32'(MEM_WORDS)};
`endif

    assign reject = (req_op == OP_RSVD) || addr_bad;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_LOAD;
            err        <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_add    <= '0;
            mem_data   <= '0;
            mem_op1    <= '0;
            mem_op2    <= '0;
        end else begin
            state      <= state_n;
            op         <= op_n;
            err        <= err_n;
            cnt        <= cnt_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_data  <= resp_data_n;
            mem_wr_en  <= mem_wr_en_n;
            mem_rd_en  <= mem_rd_en_n;
            mem_add    <= mem_add_n;
            mem_data   <= mem_data_n;
            mem_op1    <= mem_op1_n;
            mem_op2    <= mem_op2_n;
        end
    end

    // Next state and next output values; everything holds unless changed.
    always_comb begin
        state_n      = state;
        op_n         = op;
        err_n        = err;
        cnt_n        = cnt;
        resp_valid_n = resp_valid;
        resp_err_n   = resp_err;
        resp_data_n  = resp_data;
        mem_wr_en_n  = mem_wr_en;
        mem_rd_en_n  = mem_rd_en;
        mem_add_n    = mem_add;
        mem_data_n   = mem_data;
        mem_op1_n    = mem_op1;
        mem_op2_n    = mem_op2;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = ISSUE;
                    op_n    = req_op;
                    err_n   = reject;
                    cnt_n   = '0;
                    if (!reject) begin
                        case (req_op)
                            OP_LOAD: begin
                                mem_rd_en_n = 1'b1;
                                mem_add_n   = word_idx;
                            end
                            OP_STORE: begin
                                mem_wr_en_n = 1'b1;
                                mem_add_n   = word_idx;
                                mem_data_n  = req_wdata;
                            end
                            default: begin
                                mem_op1_n = req_a;
                                mem_op2_n = req_b;
                            end
                        endcase
                    end
                end
            end
            ISSUE: begin
                if (err) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                    resp_data_n  = '0;
                end else if (op == OP_STORE) begin
                    state_n      = RESP;
                    mem_wr_en_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_data_n  = '0;
                end else if ((op == OP_LOAD) && (RD_LAT == 1)) begin
                    state_n      = RESP;
                    mem_rd_en_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_data_n  = mem_rd_data;
                end else begin
                    // Loads with RD_LAT>1 and adds spend further cycles in WAIT.
                    state_n = WAIT;
                    cnt_n   = CNT_W'(1);
                end
            end
            WAIT: begin
                if ((op == OP_LOAD) && (cnt != CNT_W'(RD_LAT - 1))) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    state_n      = RESP;
                    mem_rd_en_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_data_n  = mem_rd_data;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with RD_LAT=3 and a behavioural
// memory that only presents valid read data once RD_LAT read cycles elapsed.
module tb_mem_access_ctrl;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_WORDS  = 8;
    localparam int unsigned MEM_ADDR_W = 3;
    localparam int unsigned RD_LAT     = 3;
`ifdef MEM_ACC_BOUNDS_CHK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_a, req_b;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic        mem_wr_en, mem_rd_en;
    logic [2:0]  mem_add;
    logic [31:0] mem_data, mem_op1, mem_op2, mem_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        mem_clr;
    int          rd_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .MEM_ADDR_W(MEM_ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_add(mem_add),
        .mem_data(mem_data), .mem_op1(mem_op1), .mem_op2(mem_op2),
        .mem_rd_data(mem_rd_data)
    );

    // Target memory: write on strobe, read data valid only after RD_LAT read cycles.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        end else if (mem_wr_en) begin
            mem[mem_add] <= mem_data;
        end
        rd_cnt <= mem_rd_en ? rd_cnt + 1 : 0;
    end

    always_comb begin
        if (mem_rd_en) mem_rd_data = (rd_cnt >= int'(RD_LAT) - 1) ? mem[mem_add] : 32'hBAAD_F00D;
        else           mem_rd_data = mem_op1 + mem_op2;
    end

    // Reference: expected response, latency and strobe usage of one request.
    function automatic void model(input logic [1:0] op, input logic [31:0] addr, a, b,
                                  output int lat, output logic [31:0] data, output logic err,
                                  output int wr_cyc, output int rd_cyc);
        logic bad;
        bad = (op == 2'b11) ||
              (BCHK && (op <= 2'b01) && ((addr[1:0] != 2'b00) || (addr >= 32'(MEM_WORDS * 4))));
        err = bad; wr_cyc = 0; rd_cyc = 0; data = '0;
        if (bad)              lat = 1;
        else if (op == 2'b00) begin lat = int'(RD_LAT); rd_cyc = int'(RD_LAT); data = ref_mem[addr[4:2]]; end
        else if (op == 2'b01) begin lat = 1; wr_cyc = 1; end
        else                  begin lat = 2; data = a + b; end
    endfunction

    // Drive one request and observe it until resp_valid (held with resp_ready=0).
    task automatic send(input logic [1:0] op, input logic [31:0] addr, wdata, a, b,
                        output int lat, output logic [31:0] data, output logic err,
                        output int wr_cyc, output int rd_cyc, output logic both_hi,
                        output logic [2:0] add_c1, output logic [31:0] op1_c2, op2_c2);
        int guard = 0;
        lat = -1; data = '0; err = 1'b0; wr_cyc = 0; rd_cyc = 0; both_hi = 1'b0;
        add_c1 = '0; op1_c2 = '0; op2_c2 = '0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_a = $urandom; req_b = $urandom;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 1) add_c1 = mem_add;
            if (k == 2) begin op1_c2 = mem_op1; op2_c2 = mem_op2; end
            if (mem_wr_en) wr_cyc++;
            if (mem_rd_en) rd_cyc++;
            if (mem_wr_en && mem_rd_en) both_hi = 1'b1;
            if (resp_valid) begin lat = k - 1; data = resp_data; err = resp_err; break; end
        end
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected %b",
                     {req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en}, 5'b10000);
        end
        checks++;
        if ({resp_data, mem_add, mem_data, mem_op1, mem_op2} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h %h %h %h %h expected all 0",
                     resp_data, mem_add, mem_data, mem_op1, mem_op2);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_store_load();
        int lat, wc, rc; logic [31:0] d, o1, o2; logic e, bh; logic [2:0] ad;
        send(2'b01, 32'h0C, 32'hDEAD_BEEF, '0, '0, lat, d, e, wc, rc, bh, ad, o1, o2);
        checks++; if (lat !== 1) begin failures++; $display("FAIL store_lat: got %0d expected 1", lat); end
        checks++; if (wc !== 1 || rc !== 0) begin failures++; $display("FAIL store_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wc, rc); end
        checks++; if (ad !== 3'd3) begin failures++; $display("FAIL store_addr: got %0d expected 3", ad); end
        checks++; if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL store_resp: got %h err=%b expected 0 err=0", d, e); end
        complete();
        ref_mem[3] = 32'hDEAD_BEEF;
        checks++; if (mem[3] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_mem: got %h expected deadbeef", mem[3]); end
        send(2'b00, 32'h0C, '0, '0, '0, lat, d, e, wc, rc, bh, ad, o1, o2);
        checks++; if (lat !== int'(RD_LAT)) begin failures++; $display("FAIL load_lat: got %0d expected %0d", lat, RD_LAT); end
        checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++; $display("FAIL load_data: got %h err=%b expected deadbeef err=0", d, e); end
        checks++; if (rc !== int'(RD_LAT) || wc !== 0) begin failures++; $display("FAIL load_strobes: got rd=%0d wr=%0d expected rd=%0d wr=0", rc, wc, RD_LAT); end
        complete();
    endtask

    task automatic test_add();
        int lat, wc, rc; logic [31:0] d, o1, o2; logic e, bh; logic [2:0] ad;
        send(2'b10, 32'hFFFF_FFF0, '0, 32'hFFFF_FFFF, 32'h2, lat, d, e, wc, rc, bh, ad, o1, o2);
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_lat: got %0d expected 2", lat); end
        checks++; if (d !== 32'h1 || e !== 1'b0) begin failures++; $display("FAIL add_sum: got %h err=%b expected 00000001 err=0", d, e); end
        checks++; if (wc !== 0 || rc !== 0) begin failures++; $display("FAIL add_strobes: got wr=%0d rd=%0d expected 0 0", wc, rc); end
        checks++; if (o1 !== 32'hFFFF_FFFF || o2 !== 32'h2) begin failures++; $display("FAIL add_ops: got %h %h expected ffffffff 00000002", o1, o2); end
        complete();
    endtask

    task automatic test_backpressure();
        int lat, wc, rc, guard; logic [31:0] d, o1, o2; logic e, bh, stable; logic [2:0] ad;
        send(2'b00, 32'h0C, '0, '0, '0, lat, d, e, wc, rc, bh, ad, o1, o2);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h1C; req_wdata = 32'h1234_5678;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== d || req_ready || mem_wr_en) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold: got %b expected 1", stable); end
        checks++; if (d !== ref_mem[3]) begin failures++; $display("FAIL bp_data: got %h expected %h", d, ref_mem[3]); end
        complete();
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, mem_wr_en} !== 3'b100) begin
            failures++; $display("FAIL bp_release: got %b expected 100", {req_ready, resp_valid, mem_wr_en});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_add !== 3'd7) begin
            failures++; $display("FAIL bp_next_accept: got wr=%b add=%0d expected wr=1 add=7", mem_wr_en, mem_add);
        end
        guard = 0;
        while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_next_resp: got %b expected 1", resp_valid); end
        complete();
        ref_mem[7] = 32'h1234_5678;
    endtask

    task automatic test_reserved();
        int lat, wc, rc; logic [31:0] d, o1, o2; logic e, bh; logic [2:0] ad;
        send(2'b11, 32'h04, 32'hFFFF_FFFF, 32'h5, 32'h6, lat, d, e, wc, rc, bh, ad, o1, o2);
        checks++; if (lat !== 1) begin failures++; $display("FAIL rsvd_lat: got %0d expected 1", lat); end
        checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL rsvd_resp: got err=%b data=%h expected err=1 data=0", e, d); end
        checks++; if (wc !== 0 || rc !== 0) begin failures++; $display("FAIL rsvd_strobes: got wr=%0d rd=%0d expected 0 0", wc, rc); end
        complete();
    endtask

    task automatic test_reset_mid_load();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h0C;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL rml_strobe_c: got %b expected 1", mem_rd_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_wr_en, resp_valid, req_ready} !== 4'b0001) begin
            failures++; $display("FAIL rml_after: got %b expected 0001", {mem_rd_en, mem_wr_en, resp_valid, req_ready});
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        resp_ready = 1'b0;
        checks++; if (seen !== 0) begin failures++; $display("FAIL rml_no_resp: got %0d expected 0", seen); end
    endtask

    task automatic test_bounds();
        int lat, wc, rc; logic [31:0] d, o1, o2; logic e, bh; logic [2:0] ad;
        send(2'b01, 32'h20, 32'hCAFE_F00D, '0, '0, lat, d, e, wc, rc, bh, ad, o1, o2);
        complete();
`ifdef MEM_ACC_BOUNDS_CHK_EN
        checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1) begin failures++; $display("FAIL bnd_store: got err=%b data=%h lat=%0d expected 1 0 1", e, d, lat); end
        checks++; if (wc !== 0) begin failures++; $display("FAIL bnd_store_strobe: got %0d expected 0", wc); end
        send(2'b00, 32'h06, '0, '0, '0, lat, d, e, wc, rc, bh, ad, o1, o2);
        complete();
        checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1 || rc !== 0) begin failures++; $display("FAIL bnd_load: got err=%b data=%h lat=%0d rd=%0d expected 1 0 1 0", e, d, lat, rc); end
`else
        ref_mem[0] = 32'hCAFE_F00D;
        checks++; if (e !== 1'b0 || wc !== 1) begin failures++; $display("FAIL bnd_store_trunc: got err=%b wr=%0d expected 0 1", e, wc); end
`endif
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL bnd_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_random();
        int lat, wc, rc, elat, ewc, erc, hold, sel; logic [31:0] d, o1, o2, ed, addr, wd, a, b;
        logic e, ee, bh, stable; logic [1:0] op; logic [2:0] ad;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            op = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wd = $urandom; a = $urandom; b = $urandom;
            model(op, addr, a, b, elat, ed, ee, ewc, erc);
            send(op, addr, wd, a, b, lat, d, e, wc, rc, bh, ad, o1, o2);
            hold = int'($urandom_range(0, 3));
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid || resp_data !== d || resp_err !== e) stable = 1'b0;
            end
            complete();
            if (ewc == 1) ref_mem[addr[4:2]] = wd;
            checks++;
            if (lat !== elat || d !== ed || e !== ee) begin
                failures++; $display("FAIL rnd_resp[%0d] op=%0d addr=%h: got lat=%0d data=%h err=%b expected lat=%0d data=%h err=%b",
                                     n, op, addr, lat, d, e, elat, ed, ee);
            end
            checks++;
            if (wc !== ewc || rc !== erc || bh !== 1'b0 || stable !== 1'b1) begin
                failures++; $display("FAIL rnd_strobes[%0d]: got wr=%0d rd=%0d both=%b stable=%b expected wr=%0d rd=%0d both=0 stable=1",
                                     n, wc, rc, bh, stable, ewc, erc);
            end
        end
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load();
        test_add();
        test_backpressure();
        test_reserved();
        test_reset_mid_load();
        test_bounds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
